// File: rtl/tuman_conf_loader.sv
// rtl/tuman_conf_loader.sv - TuMan32 ITCM/DTCM configuration sequencer
module tuman_conf_loader #(
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready,
  output logic        conf_rden_itcm,
  output logic        conf_wren_itcm,
  output logic [31:0] conf_addr_itcm,
  output logic [31:0] conf_wdata_itcm,
  input  logic [31:0] conf_rdata_itcm,
  output logic        conf_sel_dtcm,
  output logic        conf_rden_dtcm,
  output logic        conf_wren_dtcm,
  output logic [31:0] conf_addr_dtcm,
  output logic [31:0] conf_wdata_dtcm,
  input  logic [31:0] conf_rdata_dtcm,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_RESP
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [2:0]       WAIT_LAST = 3'(RD_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_is_rd;
  logic             r_tgt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [31:0]      r_base;
  logic [2:0]       r_wait;
  logic             r_sel;
  logic             r_rden_i, r_wren_i, r_rden_d, r_wren_d;
  logic [31:0]      r_addr_i, r_wdata_i, r_addr_d, r_wdata_d;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;

  logic             w_cmd_fire;
  logic             w_last;
  logic             w_rd_done;
  logic [31:0]      w_acc_addr;

  // cmd_ready is gated by resetn so it reads 0 while reset is held
  assign cmd_ready  = resetn && (r_state == S_IDLE || r_state == S_ADDR || r_state == S_WR);
  assign busy       = (r_state != S_IDLE);
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_last     = ((r_idx + LEN_ONE) == r_len);
  assign w_rd_done  = (r_state == S_RD_WAIT) && (r_wait == WAIT_LAST);
  assign w_acc_addr = r_base + 32'(r_idx);

  assign conf_sel_dtcm   = r_sel;
  assign conf_rden_itcm  = r_rden_i;
  assign conf_wren_itcm  = r_wren_i;
  assign conf_addr_itcm  = r_addr_i;
  assign conf_wdata_itcm = r_wdata_i;
  assign conf_rden_dtcm  = r_rden_d;
  assign conf_wren_dtcm  = r_wren_d;
  assign conf_addr_dtcm  = r_addr_d;
  assign conf_wdata_dtcm = r_wdata_d;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire && !cmd_data[31]) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (w_cmd_fire) begin
          if (r_len == '0)  w_next = S_IDLE;
          else if (r_is_rd) w_next = S_RD_ISSUE;
          else              w_next = S_WR;
        end
      end
      S_WR: begin
        if (w_cmd_fire && w_last) w_next = S_IDLE;
      end
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (w_rd_done) w_next = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (rsp_ready) w_next = w_last ? S_IDLE : S_RD_ISSUE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_is_rd     <= 1'b0;
      r_tgt       <= 1'b0;
      r_len       <= '0;
      r_idx       <= '0;
      r_base      <= '0;
      r_wait      <= '0;
      r_sel       <= 1'b1;
      r_rden_i    <= 1'b0;
      r_wren_i    <= 1'b0;
      r_rden_d    <= 1'b0;
      r_wren_d    <= 1'b0;
      r_addr_i    <= '0;
      r_wdata_i   <= '0;
      r_addr_d    <= '0;
      r_wdata_d   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rden_i <= 1'b0;
      r_wren_i <= 1'b0;
      r_rden_d <= 1'b0;
      r_wren_d <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            if (!cmd_data[31]) begin
              r_is_rd <= cmd_data[30];
              r_tgt   <= cmd_data[29];
              r_len   <= cmd_data[LEN_W-1:0];
              r_sel   <= 1'b1;
            end else begin
              // RUN (10) releases the core, HALT (11) holds it
              r_sel <= cmd_data[30];
            end
          end
        end
        S_ADDR: begin
          if (w_cmd_fire) begin
            r_base <= cmd_data;
            r_idx  <= '0;
          end
        end
        S_WR: begin
          if (w_cmd_fire) begin
            if (r_tgt) begin
              r_wren_d  <= 1'b1;
              r_addr_d  <= w_acc_addr;
              r_wdata_d <= cmd_data;
            end else begin
              r_wren_i  <= 1'b1;
              r_addr_i  <= w_acc_addr;
              r_wdata_i <= cmd_data;
            end
            r_idx <= r_idx + LEN_ONE;
          end
        end
        S_RD_ISSUE: begin
          if (r_tgt) begin
            r_rden_d <= 1'b1;
            r_addr_d <= w_acc_addr;
          end else begin
            r_rden_i <= 1'b1;
            r_addr_i <= w_acc_addr;
          end
          r_wait <= '0;
        end
        S_RD_WAIT: begin
          if (w_rd_done) begin
            r_rsp_data  <= r_tgt ? conf_rdata_dtcm : conf_rdata_itcm;
            r_rsp_valid <= 1'b1;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_RD_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_idx       <= r_idx + LEN_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tuman_conf_loader.sv
// tb/tb_tuman_conf_loader.sv - randomized self-checking bench for tuman_conf_loader
module tb_tuman_conf_loader;

  localparam int RD_LAT = 1;
  localparam int LEN_W  = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic        conf_rden_itcm, conf_wren_itcm;
  logic [31:0] conf_addr_itcm, conf_wdata_itcm, conf_rdata_itcm;
  logic        conf_sel_dtcm;
  logic        conf_rden_dtcm, conf_wren_dtcm;
  logic [31:0] conf_addr_dtcm, conf_wdata_dtcm, conf_rdata_dtcm;
  logic        busy;

  always #5 clk = ~clk;

  tuman_conf_loader #(.RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .conf_rden_itcm(conf_rden_itcm), .conf_wren_itcm(conf_wren_itcm),
    .conf_addr_itcm(conf_addr_itcm), .conf_wdata_itcm(conf_wdata_itcm),
    .conf_rdata_itcm(conf_rdata_itcm),
    .conf_sel_dtcm(conf_sel_dtcm),
    .conf_rden_dtcm(conf_rden_dtcm), .conf_wren_dtcm(conf_wren_dtcm),
    .conf_addr_dtcm(conf_addr_dtcm), .conf_wdata_dtcm(conf_wdata_dtcm),
    .conf_rdata_dtcm(conf_rdata_dtcm),
    .busy(busy)
  );

  typedef struct {
    bit          tgt;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int          cyc  = 0;
  int          viol = 0;
  logic [31:0] dev_m [2][256];
  bit          dev_w [2][256];
  logic [31:0] ref_m [2][256];
  bit          exp_sel;
  int          obs_ptr;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] init_val(input bit tgt, input logic [7:0] a);
    return (tgt ? 32'hD7C0_0000 : 32'h17C0_0000) ^ (32'(a) * 32'h0001_0203);
  endfunction

  // Memory devices: read data is valid in the cycle the registered strobe is high
  always_comb begin
    conf_rdata_itcm = 32'hBAD0_BAD0;
    conf_rdata_dtcm = 32'hBAD1_BAD1;
    if (conf_rden_itcm)
      conf_rdata_itcm = dev_w[0][conf_addr_itcm[7:0]] ? dev_m[0][conf_addr_itcm[7:0]]
                                                      : init_val(1'b0, conf_addr_itcm[7:0]);
    if (conf_rden_dtcm)
      conf_rdata_dtcm = dev_w[1][conf_addr_dtcm[7:0]] ? dev_m[1][conf_addr_dtcm[7:0]]
                                                      : init_val(1'b1, conf_addr_dtcm[7:0]);
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (conf_wren_itcm) begin
      dev_m[0][conf_addr_itcm[7:0]] <= conf_wdata_itcm;
      dev_w[0][conf_addr_itcm[7:0]] <= 1'b1;
      obs_q.push_back('{1'b0, 1'b0, conf_addr_itcm, conf_wdata_itcm, cyc});
    end
    if (conf_wren_dtcm) begin
      dev_m[1][conf_addr_dtcm[7:0]] <= conf_wdata_dtcm;
      dev_w[1][conf_addr_dtcm[7:0]] <= 1'b1;
      obs_q.push_back('{1'b1, 1'b0, conf_addr_dtcm, conf_wdata_dtcm, cyc});
    end
    if (conf_rden_itcm) obs_q.push_back('{1'b0, 1'b1, conf_addr_itcm, 32'h0, cyc});
    if (conf_rden_dtcm) obs_q.push_back('{1'b1, 1'b1, conf_addr_dtcm, 32'h0, cyc});
    if ((conf_rden_itcm && conf_wren_itcm) || (conf_rden_dtcm && conf_wren_dtcm) ||
        ((conf_rden_itcm || conf_wren_itcm) && (conf_rden_dtcm || conf_wren_dtcm)))
      viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = w;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("cmd_ready_timeout", 32'(n), 32'(0));
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
  endtask

  task automatic check_cmd(input string tag, input int spacing);
    int nobs;
    repeat (3) @(negedge clk);
    nobs = obs_q.size() - obs_ptr;
    chk({tag, "_nevents"}, 32'(nobs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
      chk({tag, "_kind"}, {30'd0, obs_q[obs_ptr+i].tgt, obs_q[obs_ptr+i].rd},
                          {30'd0, exp_q[i].tgt, exp_q[i].rd});
      chk({tag, "_addr"}, obs_q[obs_ptr+i].addr, exp_q[i].addr);
      if (!exp_q[i].rd) chk({tag, "_wdata"}, obs_q[obs_ptr+i].data, exp_q[i].data);
      if (spacing > 0 && i > 0)
        chk({tag, "_gap"}, 32'(obs_q[obs_ptr+i].cyc - obs_q[obs_ptr+i-1].cyc), 32'(spacing));
    end
    obs_ptr = obs_q.size();
    exp_q.delete();
    chk({tag, "_exclusive"}, 32'(viol), 32'(0));
    chk({tag, "_idle"}, {29'd0, busy, cmd_ready, rsp_valid}, {29'd0, 1'b0, 1'b1, 1'b0});
    chk({tag, "_sel"}, 32'(conf_sel_dtcm), 32'(exp_sel));
  endtask

  task automatic do_write(input bit tgt, input logic [31:0] base, input int len, input bit gaps);
    logic [31:0] a, d;
    send_word({2'b00, tgt, 13'($urandom), 16'(len)}, 0);
    exp_sel = 1'b1;
    chk("wr_sel_at_hdr", 32'(conf_sel_dtcm), 32'(1));
    send_word(base, gaps ? $urandom_range(0, 2) : 0);
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      a = base + 32'(i);
      ref_m[tgt][a[7:0]] = d;
      exp_q.push_back('{tgt, 1'b0, a, d, 0});
      send_word(d, gaps ? $urandom_range(0, 2) : 0);
    end
    check_cmd("wr", gaps ? 0 : 1);
  endtask

  task automatic do_read(input bit tgt, input logic [31:0] base, input int len, input int stall);
    logic [31:0] a, d0;
    int n, n0;
    bit stable;
    send_word({2'b01, tgt, 13'($urandom), 16'(len)}, 0);
    exp_sel = 1'b1;
    send_word(base, 0);
    rsp_ready = (stall == 0);
    for (int i = 0; i < len; i++) begin
      a = base + 32'(i);
      exp_q.push_back('{tgt, 1'b1, a, 32'h0, 0});
      n = 0;
      while (!rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("rsp_valid_timeout", 32'(n), 32'(0));
      if (stall > 0) begin
        d0 = rsp_data;
        n0 = obs_q.size();
        stable = 1'b1;
        repeat (stall) begin
          @(negedge clk);
          if (!rsp_valid || rsp_data !== d0) stable = 1'b0;
        end
        chk("rd_hold_stable", 32'(stable), 32'(1));
        chk("rd_no_issue_while_stalled", 32'(obs_q.size()), 32'(n0));
        rsp_ready = 1'b1;
      end
      chk("rd_data", rsp_data, ref_m[tgt][a[7:0]]);
      @(negedge clk);
      if (stall > 0) rsp_ready = 1'b0;
    end
    rsp_ready = 1'b0;
    check_cmd("rd", (stall == 0) ? RD_LAT + 2 : 0);
  endtask

  task automatic do_runhalt(input bit halt);
    send_word({1'b1, halt, 30'($urandom)}, 0);
    exp_sel = halt;
    chk(halt ? "halt_sel" : "run_sel", 32'(conf_sel_dtcm), 32'(halt));
    chk("runhalt_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    int n, op, len, stall;
    logic [31:0] base;
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 256; a++) ref_m[t][a] = init_val(t[0], a[7:0]);
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    exp_sel   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(conf_sel_dtcm), 32'(1));
    chk("rst_strobes", {28'd0, conf_rden_itcm, conf_wren_itcm, conf_rden_dtcm, conf_wren_dtcm}, 32'd0);
    chk("rst_busy_ready", {30'd0, busy, cmd_ready}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid} | rsp_data, 32'd0);
    chk("rst_addr_wdata", conf_addr_itcm | conf_wdata_itcm | conf_addr_dtcm | conf_wdata_dtcm, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {30'd0, busy, cmd_ready}, 32'd1);
    obs_ptr = obs_q.size();

    do_write(1'b0, 32'h10, 3, 1'b0);
    do_runhalt(1'b0);
    do_write(1'b1, 32'h4, 1, 1'b0);
    do_write(1'b1, 32'h8, 2, 1'b0);
    do_read(1'b1, 32'h8, 2, 5);
    do_write(1'b0, 32'hFFFF_FFFF, 2, 1'b0);
    do_write(1'b0, 32'h0000_0033, 0, 1'b0);
    do_read(1'b0, 32'h10, 3, 0);
    do_read(1'b0, 32'hFFFF_FFFF, 2, 1);
    do_runhalt(1'b0);
    do_runhalt(1'b1);

    send_word({2'b01, 1'b1, 13'd0, 16'd4}, 0);
    send_word(32'h20, 0);
    n = 0;
    while (!conf_rden_dtcm && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rd_reached_wait", 32'(conf_rden_dtcm), 32'(1));
    resetn = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_strobes", {28'd0, conf_rden_itcm, conf_wren_itcm, conf_rden_dtcm, conf_wren_dtcm}, 32'd0);
    chk("mid_rst_sel_busy", {30'd0, conf_sel_dtcm, busy}, 32'd2);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    obs_ptr = obs_q.size();
    exp_q.delete();
    exp_sel = 1'b1;
    do_write(1'b1, 32'h20, 2, 1'b0);
    do_read(1'b1, 32'h20, 2, 0);

    for (int k = 0; k < 40; k++) begin
      op    = $urandom_range(0, 9);
      len   = $urandom_range(0, 6);
      stall = $urandom_range(0, 3);
      base  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
      if (op < 4)      do_write(op[0], base, len, op[1]);
      else if (op < 8) do_read(op[0], base, len, stall);
      else             do_runhalt(op == 9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
